// File: rtl/sr_bank_pkg.sv
// Shared types and next-state resolution for the clocked SR flip-flop bank.
package sr_bank_pkg;

  typedef enum logic [1:0] {
    SR_HOLD    = 2'd0,
    SR_SET_DOM = 2'd1,
    SR_RST_DOM = 2'd2,
    SR_TOGGLE  = 2'd3
  } sr_mode_e;

  localparam int DEBOUNCE_MAX = 255;
  localparam int DEB_CNT_W    = 8;

  function automatic logic sr_next(input logic q, input logic s_eff,
                                   input logic r_eff, input sr_mode_e mode);
    logic nq;
    nq = q;
    case ({s_eff, r_eff})
      2'b10: nq = 1'b1;
      2'b01: nq = 1'b0;
      2'b11: begin
        case (mode)
          SR_SET_DOM: nq = 1'b1;
          SR_RST_DOM: nq = 1'b0;
          SR_TOGGLE:  nq = ~q;
          default:    nq = q;
        endcase
      end
      default: nq = q;
    endcase
    return nq;
  endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR channel: optional S/R debounce, registered q/qn, edge pulses and sticky conflict.
module sr_ff_cell
  import sr_bank_pkg::*;
#(
  parameter sr_mode_e MODE     = SR_RST_DOM,
  parameter int       DEBOUNCE = 1,
  parameter logic     RESET_Q  = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  input  logic en,
  input  logic clr,
  output logic q,
  output logic qn,
  output logic rise,
  output logic fall,
  output logic conflict,
  output logic conflict_evt
);

  logic s_eff;
  logic r_eff;
  logic q_reg, qn_reg, rise_reg, fall_reg, conflict_reg;
  logic q_next;

  if (DEBOUNCE > 1) begin : g_deb
    localparam logic [DEB_CNT_W-1:0] CNT_MAX = DEB_CNT_W'(DEBOUNCE - 1);
    logic [DEB_CNT_W-1:0] s_cnt_reg, r_cnt_reg;

    // Counters track consecutive high samples independently of en.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s_cnt_reg <= '0;
        r_cnt_reg <= '0;
      end else if (clr) begin
        s_cnt_reg <= '0;
        r_cnt_reg <= '0;
      end else begin
        s_cnt_reg <= !s ? '0 : (s_cnt_reg == CNT_MAX) ? CNT_MAX : s_cnt_reg + 1'b1;
        r_cnt_reg <= !r ? '0 : (r_cnt_reg == CNT_MAX) ? CNT_MAX : r_cnt_reg + 1'b1;
      end
    end

    assign s_eff = s && (s_cnt_reg == CNT_MAX);
    assign r_eff = r && (r_cnt_reg == CNT_MAX);
  end else begin : g_nodeb
    assign s_eff = s;
    assign r_eff = r;
  end

  assign conflict_evt = en && s_eff && r_eff;
  assign q_next       = en ? sr_next(q_reg, s_eff, r_eff, MODE) : q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg        <= RESET_Q;
      qn_reg       <= ~RESET_Q;
      rise_reg     <= 1'b0;
      fall_reg     <= 1'b0;
      conflict_reg <= 1'b0;
    end else if (clr) begin
      q_reg        <= RESET_Q;
      qn_reg       <= ~RESET_Q;
      rise_reg     <= ~q_reg & RESET_Q;
      fall_reg     <= q_reg & ~RESET_Q;
      conflict_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      qn_reg       <= ~q_next;
      rise_reg     <= ~q_reg & q_next;
      fall_reg     <= q_reg & ~q_next;
      conflict_reg <= conflict_reg | conflict_evt;
    end
  end

  assign q        = q_reg;
  assign qn       = qn_reg;
  assign rise     = rise_reg;
  assign fall     = fall_reg;
  assign conflict = conflict_reg;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of N_CH independent SR cells with a shared clear and a saturating conflict counter.
module sr_ff_bank
  import sr_bank_pkg::*;
#(
  parameter int              N_CH     = 4,
  parameter sr_mode_e        MODE     = SR_RST_DOM,
  parameter int              DEBOUNCE = 1,
  parameter int              CNT_W    = 8,
  parameter logic [N_CH-1:0] RESET_Q  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  s,
  input  logic [N_CH-1:0]  r,
  input  logic [N_CH-1:0]  en,
  input  logic             clr,
  output logic [N_CH-1:0]  q,
  output logic [N_CH-1:0]  qn,
  output logic [N_CH-1:0]  rise,
  output logic [N_CH-1:0]  fall,
  output logic [N_CH-1:0]  conflict,
  output logic [CNT_W-1:0] conflict_cnt
);

  logic [N_CH-1:0]  conflict_evt;
  logic [CNT_W-1:0] conflict_cnt_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    sr_ff_cell #(
      .MODE     (MODE),
      .DEBOUNCE (DEBOUNCE),
      .RESET_Q  (RESET_Q[gi])
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .s            (s[gi]),
      .r            (r[gi]),
      .en           (en[gi]),
      .clr          (clr),
      .q            (q[gi]),
      .qn           (qn[gi]),
      .rise         (rise[gi]),
      .fall         (fall[gi]),
      .conflict     (conflict[gi]),
      .conflict_evt (conflict_evt[gi])
    );
  end

  // Counts cycles, not channels: several simultaneous conflicts add one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      conflict_cnt_reg <= '0;
    end else if (clr) begin
      conflict_cnt_reg <= '0;
    end else if ((|conflict_evt) && (conflict_cnt_reg != '1)) begin
      conflict_cnt_reg <= conflict_cnt_reg + 1'b1;
    end
  end

  assign conflict_cnt = conflict_cnt_reg;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: several parameterisations share one stimulus bus.
module tb_sr_ff_bank;
  import sr_bank_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] s, r, en;
  logic       clr;

  // 0: RST_DOM, RESET_Q=0101, CNT_W=2   1: RST_DOM   2: HOLD   3: SET_DOM   4: TOGGLE   5: RST_DOM, DEBOUNCE=3
  logic [3:0] q_o    [6];
  logic [3:0] qn_o   [6];
  logic [3:0] rise_o [6];
  logic [3:0] fall_o [6];
  logic [3:0] cf_o   [6];
  logic [1:0] cnt_rd;
  logic [7:0] cnt_o  [1:5];

  int checks;
  int failures;

  sr_ff_bank #(.N_CH(4), .MODE(SR_RST_DOM), .DEBOUNCE(1), .CNT_W(2), .RESET_Q(4'b0101)) u_rd (
    .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr(clr),
    .q(q_o[0]), .qn(qn_o[0]), .rise(rise_o[0]), .fall(fall_o[0]),
    .conflict(cf_o[0]), .conflict_cnt(cnt_rd));

  sr_ff_bank #(.N_CH(4), .MODE(SR_RST_DOM), .DEBOUNCE(1), .CNT_W(8), .RESET_Q(4'b0000)) u_z (
    .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr(clr),
    .q(q_o[1]), .qn(qn_o[1]), .rise(rise_o[1]), .fall(fall_o[1]),
    .conflict(cf_o[1]), .conflict_cnt(cnt_o[1]));

  sr_ff_bank #(.N_CH(4), .MODE(SR_HOLD), .DEBOUNCE(1), .CNT_W(8), .RESET_Q(4'b0000)) u_hold (
    .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr(clr),
    .q(q_o[2]), .qn(qn_o[2]), .rise(rise_o[2]), .fall(fall_o[2]),
    .conflict(cf_o[2]), .conflict_cnt(cnt_o[2]));

  sr_ff_bank #(.N_CH(4), .MODE(SR_SET_DOM), .DEBOUNCE(1), .CNT_W(8), .RESET_Q(4'b0000)) u_set (
    .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr(clr),
    .q(q_o[3]), .qn(qn_o[3]), .rise(rise_o[3]), .fall(fall_o[3]),
    .conflict(cf_o[3]), .conflict_cnt(cnt_o[3]));

  sr_ff_bank #(.N_CH(4), .MODE(SR_TOGGLE), .DEBOUNCE(1), .CNT_W(8), .RESET_Q(4'b0000)) u_tog (
    .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr(clr),
    .q(q_o[4]), .qn(qn_o[4]), .rise(rise_o[4]), .fall(fall_o[4]),
    .conflict(cf_o[4]), .conflict_cnt(cnt_o[4]));

  sr_ff_bank #(.N_CH(4), .MODE(SR_RST_DOM), .DEBOUNCE(3), .CNT_W(8), .RESET_Q(4'b0000)) u_deb (
    .clk(clk), .rst(rst), .s(s), .r(r), .en(en), .clr(clr),
    .q(q_o[5]), .qn(qn_o[5]), .rise(rise_o[5]), .fall(fall_o[5]),
    .conflict(cf_o[5]), .conflict_cnt(cnt_o[5]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t s=%b r=%b en=%b clr=%b rst=%b | q_rd=%b q_z=%b q_deb=%b cnt_z=%0d",
             $time, s, r, en, clr, rst, q_o[0], q_o[1], q_o[5], cnt_o[1]);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    s = 4'b1111;
    step();
    s = 4'b0000;
    checks++;
    if (q_o[0] !== 4'b1111) begin
      failures++;
      $display("FAIL reset_pre_set got=%b exp=%b", q_o[0], 4'b1111);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (q_o[0] !== 4'b0101) begin
      failures++;
      $display("FAIL reset_async_q got=%b exp=%b", q_o[0], 4'b0101);
    end
    checks++;
    if (qn_o[0] !== 4'b1010) begin
      failures++;
      $display("FAIL reset_async_qn got=%b exp=%b", qn_o[0], 4'b1010);
    end
    checks++;
    if ({rise_o[0], fall_o[0], cf_o[0], cnt_rd} !== 14'd0) begin
      failures++;
      $display("FAIL reset_outs got=%b/%b/%b/%0d exp=0", rise_o[0], fall_o[0], cf_o[0], cnt_rd);
    end
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (q_o[i] !== 4'b0000 || qn_o[i] !== 4'b1111 || cnt_o[i] !== 8'd0) begin
        failures++;
        $display("FAIL reset_inst%0d got q=%b qn=%b cnt=%0d exp q=0000 qn=1111 cnt=0",
                 i, q_o[i], qn_o[i], cnt_o[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      checks++;
      if (q_o[0] !== 4'b0101 || rise_o[0] !== 4'b0000 || fall_o[0] !== 4'b0000) begin
        failures++;
        $display("FAIL idle_%0d got q=%b rise=%b fall=%b exp q=0101 rise=0000 fall=0000",
                 k, q_o[0], rise_o[0], fall_o[0]);
      end
    end
  endtask

  task automatic test_basic();
    do_clr();
    s = 4'b0001;
    step();
    checks++;
    if (q_o[1][0] !== 1'b1 || rise_o[1][0] !== 1'b1 || qn_o[1][0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_set got q=%b rise=%b qn=%b exp q=1 rise=1 qn=0",
               q_o[1][0], rise_o[1][0], qn_o[1][0]);
    end
    s = 4'b0000;
    step();
    checks++;
    if (q_o[1][0] !== 1'b1 || rise_o[1][0] !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold got q=%b rise=%b exp q=1 rise=0", q_o[1][0], rise_o[1][0]);
    end
    r = 4'b0001;
    step();
    checks++;
    if (q_o[1][0] !== 1'b0 || fall_o[1][0] !== 1'b1) begin
      failures++;
      $display("FAIL basic_reset got q=%b fall=%b exp q=0 fall=1", q_o[1][0], fall_o[1][0]);
    end
    s = 4'b0001;
    step();
    checks++;
    if (q_o[1][0] !== 1'b0 || fall_o[1][0] !== 1'b0 || cf_o[1] !== 4'b0001 || cnt_o[1] !== 8'd1) begin
      failures++;
      $display("FAIL basic_conflict got q=%b fall=%b conflict=%b cnt=%0d exp q=0 fall=0 conflict=0001 cnt=1",
               q_o[1][0], fall_o[1][0], cf_o[1], cnt_o[1]);
    end
    s = 4'b0000;
    r = 4'b0000;
  endtask

  task automatic test_modes();
    logic [2:0] exp_tog;
    exp_tog = 3'b101;
    do_clr();
    s = 4'b0010;
    r = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (q_o[2][1] !== 1'b0) begin
        failures++;
        $display("FAIL mode_hold_%0d got=%b exp=0", k, q_o[2][1]);
      end
      checks++;
      if (q_o[3][1] !== 1'b1 || rise_o[3][1] !== (k == 0)) begin
        failures++;
        $display("FAIL mode_set_%0d got q=%b rise=%b exp q=1 rise=%b", k, q_o[3][1], rise_o[3][1], k == 0);
      end
      checks++;
      if (q_o[4][1] !== exp_tog[k] || rise_o[4][1] !== exp_tog[k] || fall_o[4][1] !== ~exp_tog[k]) begin
        failures++;
        $display("FAIL mode_toggle_%0d got q=%b rise=%b fall=%b exp q=%b rise=%b fall=%b",
                 k, q_o[4][1], rise_o[4][1], fall_o[4][1], exp_tog[k], exp_tog[k], ~exp_tog[k]);
      end
    end
    checks++;
    if (cf_o[2] !== 4'b0010 || cnt_o[2] !== 8'd3) begin
      failures++;
      $display("FAIL mode_hold_conflict got conflict=%b cnt=%0d exp conflict=0010 cnt=3", cf_o[2], cnt_o[2]);
    end
    s = 4'b0000;
    r = 4'b0000;
  endtask

  task automatic test_debounce();
    logic [2:0] exp_q;
    do_clr();
    s = 4'b0100;
    step();
    step();
    s = 4'b0000;
    step();
    checks++;
    if (q_o[5][2] !== 1'b0) begin
      failures++;
      $display("FAIL deb_short got=%b exp=0", q_o[5][2]);
    end
    exp_q = 3'b100;
    s = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (q_o[5][2] !== exp_q[k] || rise_o[5][2] !== exp_q[k]) begin
        failures++;
        $display("FAIL deb_full_%0d got q=%b rise=%b exp q=%b rise=%b",
                 k, q_o[5][2], rise_o[5][2], exp_q[k], exp_q[k]);
      end
    end
    do_clr();
    step();
    step();
    #3;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (q_o[5][2] !== exp_q[k]) begin
        failures++;
        $display("FAIL deb_after_rst_%0d got=%b exp=%b", k, q_o[5][2], exp_q[k]);
      end
    end
    s = 4'b0000;
  endtask

  task automatic test_enable_clear();
    do_clr();
    en = 4'b0111;
    s  = 4'b1000;
    step();
    checks++;
    if (q_o[1][3] !== 1'b0) begin
      failures++;
      $display("FAIL en_off got=%b exp=0", q_o[1][3]);
    end
    en = 4'b1111;
    step();
    checks++;
    if (q_o[1][3] !== 1'b1 || rise_o[1][3] !== 1'b1) begin
      failures++;
      $display("FAIL en_on got q=%b rise=%b exp q=1 rise=1", q_o[1][3], rise_o[1][3]);
    end
    s = 4'b0001;
    r = 4'b0001;
    step();
    s = 4'b1111;
    r = 4'b0000;
    step();
    checks++;
    if (q_o[1] !== 4'b1111 || qn_o[1] !== 4'b0000 || cf_o[1] !== 4'b0001 || cnt_o[1] !== 8'd1) begin
      failures++;
      $display("FAIL pre_clr got q=%b qn=%b conflict=%b cnt=%0d exp q=1111 qn=0000 conflict=0001 cnt=1",
               q_o[1], qn_o[1], cf_o[1], cnt_o[1]);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    s   = 4'b0000;
    checks++;
    if (q_o[1] !== 4'b0000 || qn_o[1] !== 4'b1111 || fall_o[1] !== 4'b1111) begin
      failures++;
      $display("FAIL clr_q got q=%b qn=%b fall=%b exp q=0000 qn=1111 fall=1111", q_o[1], qn_o[1], fall_o[1]);
    end
    checks++;
    if (cf_o[1] !== 4'b0000 || cnt_o[1] !== 8'd0) begin
      failures++;
      $display("FAIL clr_conflict got conflict=%b cnt=%0d exp conflict=0000 cnt=0", cf_o[1], cnt_o[1]);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_clr();
    s = 4'b0001;
    r = 4'b0001;
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (cnt_rd !== exp_cnt[k]) begin
        failures++;
        $display("FAIL sat_cnt_%0d got=%0d exp=%0d", k, cnt_rd, exp_cnt[k]);
      end
    end
    s = 4'b0000;
    r = 4'b0000;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b1;
    clr = 1'b0;
    s   = 4'b0000;
    r   = 4'b0000;
    en  = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_basic();
    test_modes();
    test_debounce();
    test_enable_clear();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
Parametrised bank of N_CH independent clocked SR flip-flops. It is the multi-channel successor of the single clocked SR flip-flop. Each channel has:
- a selectable conflict-resolution mode for S=R=1,
- an optional input debounce filter,
- a per-channel update enable and a bank-wide synchronous clear,
- registered rise/fall pulses and conflict reporting.

It sits between raw control or status strobes and downstream logic that needs a held, glitch-filtered flag.

Parameters:
N_CH, 4, number of channels (1..32).
MODE, SR_RST_DOM, S=R=1 resolution; one of SR_HOLD, SR_SET_DOM, SR_RST_DOM, SR_TOGGLE.
DEBOUNCE, 1, consecutive cycles S or R must be high before acting (1..255); 1 means no filter.
CNT_W, 8, width of the saturating conflict counter.
RESET_Q, '0 (N_CH bits), per-channel value of q after rst/clr.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset
s  in  N_CH  per-channel set request
r  in  N_CH  per-channel reset request
en  in  N_CH  per-channel state-update enable
clr  in  1  synchronous clear of whole bank
q  out  N_CH  channel state
qn  out  N_CH  complement of q
rise  out  N_CH  1-cycle pulse, q went 0->1
fall  out  N_CH  1-cycle pulse, q went 1->0
conflict  out  N_CH  sticky: channel saw effective S=R=1 while enabled
conflict_cnt  out  CNT_W  saturating count of cycles with any enabled conflict

Behaviour:
- Reset: one clock (clk). rst is asynchronous and active-high.
- While rst is high, outputs and internal state are:
  - q=RESET_Q and qn=~RESET_Q,
  - rise=fall=0, conflict=0, conflict_cnt=0,
  - all debounce counters 0.
- Deassertion of rst: the first state change can occur on the first rising edge after rst falls.
- Invariant qn == ~q at all times, including during reset. qn is registered, not derived combinationally downstream.
- Debounce (per channel, separately for S and R):
  - s_cnt counts consecutive edges with s[i]=1 and saturates at DEBOUNCE-1. s[i]=0 at an edge zeroes it.
  - s_eff = s[i] && (s_cnt == DEBOUNCE-1). r_eff is formed the same way from r[i].
  - Counters run regardless of en.
  - With DEBOUNCE=1 the counters are absent; s_eff=s and r_eff=r.
- Latency: S held high across D=DEBOUNCE consecutive edges updates q at the D-th edge. For D=1 this is the same edge it is sampled.
- Next state at each edge, only if en[i]=1 (en[i]=0 holds q[i]). Cases on (s_eff, r_eff):
  - 00: hold.
  - 10: q=1.
  - 01: q=0.
  - 11, by MODE: SR_HOLD holds; SR_SET_DOM gives q=1; SR_RST_DOM gives q=0; SR_TOGGLE gives q=~q.
  - In SR_TOGGLE with S=R held high, q toggles every enabled edge.
- rise[i]/fall[i]:
  - Registered together with q, high exactly in the cycle q[i] first shows its new value.
  - Low otherwise, and low on any edge where q is unchanged.
- Conflict reporting:
  - conflict[i] sets at any edge with en[i] && s_eff && r_eff, in every MODE. It stays set until clr or rst.
  - conflict_cnt increments by 1 per edge where at least one channel has an enabled conflict. It saturates at 2^CNT_W-1 and does not wrap.
- clr (synchronous; priority over all other inputs except rst):
  - At the edge sets q=RESET_Q and qn=~RESET_Q.
  - Zeroes debounce counters, conflict and conflict_cnt.
  - Ignores en.
  - rise/fall reflect the q change caused by clr (channel at 1 with RESET_Q=0 produces a fall pulse).
- Reset mid-debounce: counters are lost, and the count restarts from zero after release.
- Channels are fully independent apart from the shared clr and conflict_cnt.

Decomposition:
- Package sr_bank_pkg holds:
  - typedef enum logic [1:0] sr_mode_e {SR_HOLD=0, SR_SET_DOM=1, SR_RST_DOM=2, SR_TOGGLE=3},
  - constant DEBOUNCE_MAX=255,
  - a function resolving next q from (q, s_eff, r_eff, mode).
- One sub-module sr_ff_cell: a single channel with its debounce counters, q/qn, rise/fall and conflict flag. It exports a conflict-event bit.
- The top generates N_CH cells, ORs the conflict events and owns conflict_cnt.

Test Plan:
- Reset/idle (N_CH=4, RESET_Q=4'b0101): rst pulsed asynchronously mid-cycle -> q=0101 and qn=1010 immediately, all other outputs 0. s=r=0 for 10 cycles after release -> no change, no pulses.
- Basic SR, DEBOUNCE=1, MODE=SR_RST_DOM, ch0:
  - s=1 for 1 edge -> q[0]=1 and rise[0]=1 for one cycle.
  - then r=1 -> q[0]=0 with fall[0]=1.
  - then s=r=1 -> q[0]=0, conflict[0]=1, conflict_cnt=1.
- Modes on ch1, s=r=1 held for 3 enabled edges, starting q=0:
  - SR_HOLD -> 0,0,0.
  - SR_SET_DOM -> 1,1,1.
  - SR_TOGGLE -> 1,0,1, with alternating rise/fall pulses.
- Debounce DEBOUNCE=3:
  - s[2] high for 2 edges then low -> no change.
  - s[2] high for 3 edges -> q[2]=1 at the 3rd edge.
  - rst asserted after 2 of 3 edges -> after release, 3 fresh edges are needed.
- Enable/clear:
  - en[3]=0 with s[3]=1 -> q[3] holds 0; en[3]=1 -> q[3]=1.
  - clr with q=1111, RESET_Q=0 -> q=0000, fall=1111, conflict=0, conflict_cnt=0.
- Saturation (CNT_W=2): 5 consecutive conflict edges -> conflict_cnt sequence 1,2,3,3,3.
